// File: rtl/gallery_page_ctrl_if.sv
// Gallery page controller bus: key-control pulses and gallery mode coming in,
// SD read handshake and gallery status going out.
interface gallery_page_ctrl_if #(
    parameter int unsigned IDX_W = 4
);
    logic              en_gallery;
    logic              page_up;
    logic              page_down;
    logic              photo_save;
    logic              saved;
    logic              sd_read_ack;
    logic              sd_read_done;
    logic              sd_read_req;
    logic [31:0]       sd_read_sec;
    logic [31:0]       sd_save_sec;
    logic [IDX_W-1:0]  page_idx;
    logic [IDX_W:0]    photo_cnt;
    logic              gallery_empty;
    logic              busy;

    // Upstream side: system control stage and SD read engine drive the inputs
    modport master (
        output en_gallery, page_up, page_down, photo_save, saved,
               sd_read_ack, sd_read_done,
        input  sd_read_req, sd_read_sec, sd_save_sec, page_idx, photo_cnt,
               gallery_empty, busy
    );

    // Controller side
    modport slave (
        input  en_gallery, page_up, page_down, photo_save, saved,
               sd_read_ack, sd_read_done,
        output sd_read_req, sd_read_sec, sd_save_sec, page_idx, photo_cnt,
               gallery_empty, busy
    );
endinterface

// File: rtl/gallery_page_ctrl.sv
// Gallery page controller: counts stored photos, picks the next save slot
// (ring overwrite), tracks the displayed page and requests SD sector loads.
module gallery_page_ctrl #(
    parameter int unsigned MAX_PHOTOS        = 16,
    parameter int unsigned IDX_W             = 4,
    parameter int unsigned SECTORS_PER_PHOTO = 1200,
    parameter logic [31:0] BASE_SECTOR       = 32'h0000_8000
) (
    input logic                clk,
    input logic                reset,
    gallery_page_ctrl_if.slave bus
);

    localparam logic [IDX_W:0]   MAX_CNT   = (IDX_W+1)'(MAX_PHOTOS);
    localparam logic [IDX_W-1:0] LAST_SLOT = (IDX_W)'(MAX_PHOTOS - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD_REQ,
        LOADING,
        SAVE_WAIT
    } state_t;

    state_t           state_q;
    logic             en_gallery_q;
    logic             sd_read_req_q;
    logic [31:0]      sd_read_sec_q;
    logic [31:0]      sd_save_sec_q;
    logic [IDX_W-1:0] page_idx_q;
    logic [IDX_W-1:0] wr_slot_q;
    logic [IDX_W:0]   photo_cnt_q;
    logic             gallery_empty_q;
    logic             busy_q;

    logic             load_go_d;
    logic [IDX_W-1:0] load_idx_d;
    logic [IDX_W:0]   cnt_m1;
    logic             gallery_rise;

    function automatic logic [31:0] sec_of(input logic [IDX_W-1:0] idx);
        return BASE_SECTOR + 32'(idx) * SECTORS_PER_PHOTO;
    endfunction

    assign cnt_m1       = photo_cnt_q - 1'b1;
    assign gallery_rise = bus.en_gallery & ~en_gallery_q;

    // Decide whether an idle cycle starts a page load, and which page it targets
    always_comb begin
        load_go_d  = 1'b0;
        load_idx_d = page_idx_q;
        if (bus.en_gallery && (photo_cnt_q != '0)) begin
            if (gallery_rise) begin
                load_go_d = 1'b1;
            end else if (bus.page_up && !bus.page_down) begin
                load_go_d  = 1'b1;
                load_idx_d = ({1'b0, page_idx_q} == cnt_m1) ? '0 : page_idx_q + 1'b1;
            end else if (bus.page_down && !bus.page_up) begin
                load_go_d  = 1'b1;
                load_idx_d = (page_idx_q == '0) ? cnt_m1[IDX_W-1:0] : page_idx_q - 1'b1;
            end
        end
    end

    // Main controller FSM with registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            en_gallery_q    <= 1'b0;
            sd_read_req_q   <= 1'b0;
            sd_read_sec_q   <= BASE_SECTOR;
            page_idx_q      <= '0;
            wr_slot_q       <= '0;
            photo_cnt_q     <= '0;
            gallery_empty_q <= 1'b1;
            busy_q          <= 1'b0;
        end else begin
            en_gallery_q <= bus.en_gallery;
            case (state_q)
                IDLE: begin
                    if (load_go_d) begin
                        page_idx_q    <= load_idx_d;
                        sd_read_sec_q <= sec_of(load_idx_d);
                        sd_read_req_q <= 1'b1;
                        busy_q        <= 1'b1;
                        state_q       <= LOAD_REQ;
                    end else if (!bus.en_gallery && bus.photo_save) begin
                        busy_q  <= 1'b1;
                        state_q <= SAVE_WAIT;
                    end
                end
                LOAD_REQ: begin
                    if (bus.sd_read_ack) begin
                        sd_read_req_q <= 1'b0;
                        if (bus.sd_read_done) begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            state_q <= LOADING;
                        end
                    end
                end
                LOADING: begin
                    if (bus.sd_read_done) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                SAVE_WAIT: begin
                    if (bus.saved) begin
                        page_idx_q      <= wr_slot_q;
                        wr_slot_q       <= (wr_slot_q == LAST_SLOT) ? '0 : wr_slot_q + 1'b1;
                        photo_cnt_q     <= (photo_cnt_q == MAX_CNT) ? MAX_CNT : photo_cnt_q + 1'b1;
                        gallery_empty_q <= 1'b0;
                        busy_q          <= 1'b0;
                        state_q         <= IDLE;
                    end
                end
                default: begin
                    sd_read_req_q <= 1'b0;
                    busy_q        <= 1'b0;
                    state_q       <= IDLE;
                end
            endcase
        end
    end

    // Save sector follows the write slot one cycle later
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sd_save_sec_q <= BASE_SECTOR;
        end else begin
            sd_save_sec_q <= sec_of(wr_slot_q);
        end
    end

    assign bus.sd_read_req   = sd_read_req_q;
    assign bus.sd_read_sec   = sd_read_sec_q;
    assign bus.sd_save_sec   = sd_save_sec_q;
    assign bus.page_idx      = page_idx_q;
    assign bus.photo_cnt     = photo_cnt_q;
    assign bus.gallery_empty = gallery_empty_q;
    assign bus.busy          = busy_q;

endmodule
